rom_loader: RTL and testbench
=============================

# rom_loader

UART boot loader that sits directly upstream of the instruction ROM and drives its write port. It receives a framed program image over a serial line (8N1) and assembles little-endian 32-bit words. It then issues one ROM write per word at consecutive word-aligned byte addresses starting at 0. While a load is in progress it holds the CPU core in reset.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: serial bit rate. Bit period `DIV = CLK_FREQ/BAUD`, truncated (434 at defaults).
- `SYNC_BYTE`, 8'hA5: frame start marker.

- `clk` input 1: system clock.
- `rstn` input 1: reset, asynchronous assert, active-low.
- `rx_i` input 1: UART receive line, asynchronous, idles high.
- `we_o` output 1: ROM write strike, one-cycle pulse per word.
- `addr_o` output `MemAddrBus` (32): ROM byte address, always a multiple of 4.
- `data_o` output `MemBus` (32): ROM write data.
- `hold_o` output 1: hold core in reset while high.
- `done_o` output 1: last load completed successfully (level).
- `err_o` output 1: last load aborted or failed (level).

## Operation
- Frame layout: `SYNC_BYTE`, `LEN_L`, `LEN_H`, then `LEN` words of 4 bytes each (LSB first). With `LOADER_CHECKSUM_EN` defined, one checksum byte follows.
- States:
  - IDLE: discard every byte other than `SYNC_BYTE`. On sync: go to LEN0, set `hold_o`=1, clear `done_o` and `err_o`, reset the word index to 0.
  - LEN0: latch the low byte of `LEN`, go to LEN1.
  - LEN1: latch the high byte of `LEN`. If `LEN`=0, go to CSUM when the macro is defined, else DONE. Otherwise go to DATA.
  - DATA: 2-bit byte counter shifts bytes in.
    - On the 4th byte: `data_o` = {b3,b2,b1,b0}, `addr_o` = index<<2, pulse `we_o`, increment index.
    - When index reaches `LEN`: go to CSUM (macro defined) or DONE.
  - CSUM: compare the received byte to the accumulated sum, go to DONE.
  - DONE: set `done_o`=1 (or `err_o`=1 on checksum mismatch), `hold_o`=0, then return to IDLE on the next cycle.
- Address wraps modulo 2^32. No range check: the ROM ignores out-of-range writes.
- Framing error (stop bit sampled low) in any state except IDLE: set `err_o`=1, `hold_o`=0, `done_o`=0, go to IDLE. Words already written stay written.
- A framing error in IDLE is ignored.
- A `SYNC_BYTE` value received inside DATA or LEN is treated as data, not as a restart.

## Timing
- Reset values: `we_o`=0, `addr_o`=0, `data_o`=0, `hold_o`=0, `done_o`=0, `err_o`=0. FSM goes to IDLE and the receiver goes to idle.
- Reset asserted mid-load aborts the load immediately. No further writes occur and `hold_o` drops asynchronously.
- Receiver:
  - `rx_i` passes through a 2-flop synchronizer; a falling edge starts reception.
  - Start bit is re-sampled at `DIV/2`. If it is high, the event is a false start and the receiver returns to idle.
  - Data bits are sampled every `DIV` cycles, LSB first. The stop bit is sampled `DIV` cycles after bit 7.
  - The byte-valid pulse is 1 cycle, issued at the stop-bit sample.
- `we_o`, `addr_o`, `data_o`, and `done_o`/`err_o` update in the cycle after the relevant byte-valid pulse. `addr_o`/`data_o` hold their value until the next write.
- `we_o` is never high for two consecutive cycles. Minimum spacing between writes is 4 byte times.

## Configuration
- `LOADER_CHECKSUM_EN`:
  - Defined: an 8-bit sum (mod 256) of all data bytes, excluding sync and length, is accumulated. The trailing byte is compared against it. On mismatch, `err_o`=1 and `done_o`=0. `hold_o` still drops, because the writes have already happened.
  - Undefined: no CSUM state and no accumulator. DATA goes straight to DONE.

## Structure
- The shared define header holds:
  - `MemAddrBus`/`MemBus`.
  - Loader state encodings (`LdIdle`, `LdLen0`, `LdLen1`, `LdData`, `LdCsum`, `LdDone`).
  - Default `SYNC_BYTE`.
- One sub-module: `uart_rx`.
  - Contains the synchronizer, baud counter and bit shifter.
  - Outputs `byte_o[7:0]`, `valid_o` and `frame_err_o` pulses.
- The framing FSM and write generation live in `rom_loader`.

## Test plan
- Reset with `rx_i`=1 → all outputs 0. Assert `rstn` mid-frame → `hold_o` drops at once and no `we_o` follows.
- Send A5 02 00 13 00 00 00 93 00 10 00 (+B6 with the macro) → two `we_o` pulses:
  - addr 0x0 / data 0x00000013.
  - addr 0x4 / data 0x00100093.
  - Then `done_o`=1, `hold_o`=0, `err_o`=0.
- Send A5 00 00 (+00 with the macro) → no `we_o`, `done_o`=1.
- Send 55 then 3C in IDLE → no state change, `hold_o` stays 0.
- A5 01 00 13 00 then a byte with stop bit 0 → `err_o`=1, `hold_o`=0, no `we_o`. A following valid frame clears `err_o`.
- Macro defined: frame from test 2 with checksum B7 → writes occur, `err_o`=1, `done_o`=0.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared bus types, state encodings and defaults for the ROM boot loader
package rom_loader_pkg;

  typedef logic [31:0] MemAddrBus;
  typedef logic [31:0] MemBus;

  localparam logic [7:0] DefaultSyncByte = 8'hA5;

  typedef enum logic [2:0] {
    LdIdle = 3'd0,
    LdLen0 = 3'd1,
    LdLen1 = 3'd2,
    LdData = 3'd3,
    LdCsum = 3'd4,
    LdDone = 3'd5
  } ld_state_e;

  typedef enum logic [1:0] {
    RxIdle  = 2'd0,
    RxStart = 2'd1,
    RxData  = 2'd2,
    RxStop  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: 2-flop synchronizer, baud counter, LSB-first shifter
// Emits one-cycle valid_o or frame_err_o pulses at the stop-bit sample.
module uart_rx
  import rom_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DIV - 1);
  localparam logic [CW-1:0] HalfCnt = CW'(DIV / 2 - 1);

  rx_state_e      state_q, state_d;
  logic           rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           falling;
  logic           cnt_wrap, sample_bit, stop_tick;

  assign falling = rx_prev & ~rx_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RxIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RxIdle:  if (falling) state_d = RxStart;
      RxStart: if (cnt_q == HalfCnt) state_d = rx_sync ? RxIdle : RxData;
      RxData:  if (cnt_q == FullCnt && bit_q == 3'd7) state_d = RxStop;
      RxStop:  if (cnt_q == FullCnt) state_d = RxIdle;
      default: state_d = RxIdle;
    endcase
  end

  always_comb begin
    sample_bit = (state_q == RxData) && (cnt_q == FullCnt);
    stop_tick  = (state_q == RxStop) && (cnt_q == FullCnt);
    cnt_wrap   = sample_bit || stop_tick || (state_q == RxStart && cnt_q == HalfCnt);
  end

  // Idle line resets high so a reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_meta     <= rx_i;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      cnt_q       <= (state_q == RxIdle || cnt_wrap) ? '0 : cnt_q + CW'(1);
      valid_o     <= stop_tick & rx_sync;
      frame_err_o <= stop_tick & ~rx_sync;
      if (state_q == RxStart) bit_q <= '0;
      else if (sample_bit)    bit_q <= bit_q + 3'd1;
      if (sample_bit) shift_q <= {rx_sync, shift_q[7:1]};
      if (stop_tick)  byte_o  <= shift_q;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - UART boot loader driving the instruction ROM write port, holding the core meanwhile
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte over the data bytes.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = DefaultSyncByte
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      rx_i,
  output logic      we_o,
  output MemAddrBus addr_o,
  output MemBus     data_o,
  output logic      hold_o,
  output logic      done_o,
  output logic      err_o
);

  localparam int Div = CLK_FREQ / BAUD;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_e TailState = LdCsum;
`else
  localparam ld_state_e TailState = LdDone;
`endif

  ld_state_e   state_q, state_d;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;
  logic [15:0] len_q, idx_q;
  logic [1:0]  bcnt_q;
  logic [23:0] shift_q;
  logic        word_strobe, last_word;
  logic        start_load, abort, finish, csum_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
`endif

  uart_rx #(.DIV(Div)) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .rx_i       (rx_i),
    .byte_o     (rx_byte),
    .valid_o    (rx_valid),
    .frame_err_o(rx_ferr)
  );

  assign word_strobe = rx_valid && (state_q == LdData) && (bcnt_q == 2'd3);
  assign last_word   = (idx_q + 16'd1) == len_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= LdIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_ferr && state_q != LdIdle) begin
      state_d = LdIdle;
    end else begin
      unique case (state_q)
        LdIdle: if (rx_valid && rx_byte == SYNC_BYTE) state_d = LdLen0;
        LdLen0: if (rx_valid) state_d = LdLen1;
        LdLen1: if (rx_valid) state_d = ({rx_byte, len_q[7:0]} == 16'd0) ? TailState : LdData;
        LdData: if (word_strobe && last_word) state_d = TailState;
`ifdef LOADER_CHECKSUM_EN
        LdCsum: if (rx_valid) state_d = LdDone;
`endif
        LdDone: state_d = LdIdle;
        default: state_d = LdIdle;
      endcase
    end
  end

  // Status flags change on entry to DONE so they land one cycle after the last byte.
  always_comb begin
    start_load = (state_q == LdIdle) && (state_d == LdLen0);
    abort      = rx_ferr && (state_q != LdIdle);
    finish     = (state_d == LdDone) && (state_q != LdDone);
`ifdef LOADER_CHECKSUM_EN
    csum_bad   = (state_q == LdCsum) && (rx_byte != sum_q);
`else
    csum_bad   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_o    <= 1'b0;
      addr_o  <= '0;
      data_o  <= '0;
      hold_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      we_o <= word_strobe;
      if (word_strobe) begin
        addr_o <= {14'd0, idx_q, 2'b00};
        data_o <= {rx_byte, shift_q};
        idx_q  <= idx_q + 16'd1;
      end
      if (rx_valid && state_q == LdData) begin
        bcnt_q  <= bcnt_q + 2'd1;
        shift_q <= {rx_byte, shift_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
        sum_q   <= sum_q + rx_byte;
`endif
      end
      if (rx_valid && state_q == LdLen0) len_q[7:0]  <= rx_byte;
      if (rx_valid && state_q == LdLen1) len_q[15:8] <= rx_byte;
      if (start_load) begin
        hold_o <= 1'b1;
        done_o <= 1'b0;
        err_o  <= 1'b0;
        idx_q  <= '0;
        bcnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum_q  <= '0;
`endif
      end
      if (abort) begin
        hold_o <= 1'b0;
        done_o <= 1'b0;
        err_o  <= 1'b1;
      end else if (finish) begin
        hold_o <= 1'b0;
        done_o <= ~csum_bad;
        err_o  <= csum_bad;
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - self-checking bench for rom_loader with a frame-level reference model
module tb_rom_loader;

  localparam int Div = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_i = 1'b1;
  logic        we_o, hold_o, done_o, err_o;
  logic [31:0] addr_o, data_o;

  int total = 0;
  int bad = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic        prev_we = 1'b0;
  logic        exp_err;

  rom_loader #(.CLK_FREQ(1_600_000), .BAUD(100_000), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rx_i  (rx_i),
    .we_o  (we_o),
    .addr_o(addr_o),
    .data_o(data_o),
    .hold_o(hold_o),
    .done_o(done_o),
    .err_o (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we_o) begin
      check("we_spacing", {63'd0, prev_we}, 64'd0);
      obs_q.push_back({addr_o, data_o});
    end
    prev_we = we_o;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx_i = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (Div) @(negedge clk);
    end
    rx_i = stop;
    repeat (Div) @(negedge clk);
    rx_i = 1'b1;
    repeat (stop ? Div : 2 * Div) @(negedge clk);
  endtask

  // Sends a full frame; the trailing sum is sum(data) ^ csum_xor when checksums are built in.
  task automatic send_frame(input logic [7:0] dat[$], input int nwords, input logic [7:0] csum_xor);
    logic [7:0] sum;
    sum = 8'd0;
    send_byte(8'hA5, 1'b1);
    send_byte(nwords[7:0], 1'b1);
    send_byte(nwords[15:8], 1'b1);
    foreach (dat[i]) begin
      send_byte(dat[i], 1'b1);
      sum = sum + dat[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum ^ csum_xor, 1'b1);
`else
    if (csum_xor != 8'd0) sum = 8'd0;
`endif
  endtask

  task automatic build_expected(input logic [7:0] dat[$], input int nwords);
    exp_q.delete();
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] word;
      word = 32'd0;
      for (int k = 0; k < 4; k++) word = word + (32'(dat[4*w+k]) << (8 * k));
      exp_q.push_back({32'(w * 4), word});
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check({tag, "_wr"}, obs_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] d[$];
    int nw;

    repeat (4) @(negedge clk);
    check("rst_we", {63'd0, we_o}, 64'd0);
    check("rst_addr", {32'd0, addr_o}, 64'd0);
    check("rst_data", {32'd0, data_o}, 64'd0);
    check("rst_hold", {63'd0, hold_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word program image
    obs_q.delete();
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame(d, 2, 8'h00);
    check("t2_nwr", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("t2_w0", obs_q[0], {32'h0, 32'h00000013});
      check("t2_w1", obs_q[1], {32'h4, 32'h00100093});
    end
    check("t2_done", {63'd0, done_o}, 64'd1);
    check("t2_hold", {63'd0, hold_o}, 64'd0);
    check("t2_err", {63'd0, err_o}, 64'd0);

    // Empty frame
    obs_q.delete();
    d.delete();
    send_frame(d, 0, 8'h00);
    check("t3_nwr", 64'(obs_q.size()), 64'd0);
    check("t3_done", {63'd0, done_o}, 64'd1);
    check("t3_hold", {63'd0, hold_o}, 64'd0);

    // Non-sync bytes in IDLE are discarded
    send_byte(8'h55, 1'b1);
    send_byte(8'h3C, 1'b1);
    check("t4_hold", {63'd0, hold_o}, 64'd0);
    check("t4_done", {63'd0, done_o}, 64'd1);
    check("t4_nwr", 64'(obs_q.size()), 64'd0);

    // Framing error mid-word
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t5_hold_busy", {63'd0, hold_o}, 64'd1);
    check("t5_done_busy", {63'd0, done_o}, 64'd0);
    send_byte(8'h00, 1'b0);
    check("t5_err", {63'd0, err_o}, 64'd1);
    check("t5_hold", {63'd0, hold_o}, 64'd0);
    check("t5_done", {63'd0, done_o}, 64'd0);
    check("t5_nwr", 64'(obs_q.size()), 64'd0);
    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(d, 1, 8'h00);
    check("t5_recover_err", {63'd0, err_o}, 64'd0);
    check("t5_recover_done", {63'd0, done_o}, 64'd1);
    check("t5_recover_nwr", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) check("t5_recover_w0", obs_q[0], {32'h0, 32'hDEADBEEF});

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: writes land, then error
    obs_q.delete();
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame(d, 2, 8'h01);
    check("t6_nwr", 64'(obs_q.size()), 64'd2);
    check("t6_err", {63'd0, err_o}, 64'd1);
    check("t6_done", {63'd0, done_o}, 64'd0);
    check("t6_hold", {63'd0, hold_o}, 64'd0);
`endif

    // Reset in the middle of a frame
    obs_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("rm_hold_before", {63'd0, hold_o}, 64'd1);
    #2 rstn = 1'b0;
    #1 check("rm_hold_async", {63'd0, hold_o}, 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check("rm_nwr", 64'(obs_q.size()), 64'd0);
    check("rm_hold_after", {63'd0, hold_o}, 64'd0);
    check("rm_done_after", {63'd0, done_o}, 64'd0);

    // Randomized frames against the model; sync values appear as data
    for (int f = 0; f < 5; f++) begin
      logic [7:0] x;
      obs_q.delete();
      nw = $urandom_range(1, 4);
      d.delete();
      for (int i = 0; i < 4 * nw; i++)
        d.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom));
      x = 8'h00;
      exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(0, 2) == 0) begin
        x = 8'($urandom_range(1, 255));
        exp_err = 1'b1;
      end
`endif
      build_expected(d, nw);
      send_frame(d, nw, x);
      compare_writes("rnd");
      check("rnd_done", {63'd0, done_o}, {63'd0, ~exp_err});
      check("rnd_err", {63'd0, err_o}, {63'd0, exp_err});
      check("rnd_hold", {63'd0, hold_o}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
